command_word_sequencer: RTL and testbench
=========================================

COMMAND_WORD_SEQUENCER -- requirements
Module: command_word_sequencer

Interface
REQ-001 SHALL have parameter ALLOW_OCW_BEFORE_INIT, default 0: when 1, OCW writes are accepted before the first complete initialization.
REQ-002 SHALL have port clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port chip_select_n, input, 1 bit: active-low device select.
REQ-005 SHALL have port write_enable_n, input, 1 bit: active-low CPU write strobe.
REQ-006 SHALL have port address, input, 1 bit: A0 register select.
REQ-007 SHALL have port data_bus_in, input, 8 bits: CPU write data.
REQ-008 SHALL have port internal_data_bus, output, 8 bits: data of the last committed write.
REQ-009 SHALL have ports write_initial_command_word_1 through write_initial_command_word_4, output, 1 bit each: one-cycle ICW1–ICW4 strobes.
REQ-010 SHALL have ports write_operation_control_word_1 through write_operation_control_word_3, output, 1 bit each: one-cycle OCW1–OCW3 strobes.
REQ-011 SHALL have port initialization_done, output, 1 bit: high when in READY.
REQ-012 SHALL have port sequence_error, output, 1 bit: one-cycle pulse when a write is discarded.

Function
REQ-013 SHALL sample chip_select_n, write_enable_n, address and data_bus_in every cycle into a one-stage capture register.
REQ-014 SHALL commit a write in the cycle after the sampled write_enable_n goes from 0 to 1, provided the sampled chip_select_n was 0 in the cycle of the 0 sample; address and data are those captured in that last-low cycle.
REQ-015 SHALL, on commit, drive internal_data_bus with the captured data and assert exactly one strobe, or sequence_error, for one cycle; the latency from the write_enable_n rising sample to the strobe is 1 cycle.
REQ-016 SHALL implement states UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4 and READY.
REQ-017 SHALL treat address=0 with data[4]=1 as ICW1 in any state: pulse ICW1, latch SNGL=data[1] and IC4=data[0], go to WAIT_ICW2.
REQ-018 In WAIT_ICW2, address=1 SHALL pulse ICW2, then go to WAIT_ICW3 if SNGL=0, else WAIT_ICW4 if IC4=1, else READY.
REQ-019 In WAIT_ICW3, address=1 SHALL pulse ICW3, then go to WAIT_ICW4 if IC4=1, else READY.
REQ-020 In WAIT_ICW4, address=1 SHALL pulse ICW4 and go to READY.
REQ-021 In WAIT_ICW2/3/4, address=0 with data[4]=0 SHALL be discarded with sequence_error, and the state SHALL hold.
REQ-022 In READY, address=1 SHALL pulse OCW1; address=0 with data[4:3]=00 SHALL pulse OCW2; address=0 with data[4:3]=01 SHALL pulse OCW3; address=0 with data[4:3]=11 SHALL be discarded with sequence_error.
REQ-023 In UNINIT, non-ICW1 writes SHALL be decoded as in READY when ALLOW_OCW_BEFORE_INIT=1, and otherwise discarded with sequence_error.
REQ-024 SHALL ignore a write_enable_n rise with chip_select_n high; a chip_select_n change during a low strobe SHALL use the value sampled in the last-low cycle.
REQ-025 SHALL require back-to-back writes to be at least 2 cycles apart (low then high); writes spaced more closely are outside the supported protocol.

Reset
REQ-026 With reset_n=0 at a rising edge, the block SHALL enter UNINIT, clear SNGL, IC4 and the capture register (write_enable_n and chip_select_n sampled as 1), drive internal_data_bus=8'h00, drive all strobes, initialization_done and sequence_error to 0, and suppress any pending commit.
REQ-027 Reset asserted mid-sequence, e.g. in WAIT_ICW3, SHALL return to UNINIT with no strobe generated.

Structure
REQ-028 A shared package SHALL hold the state encoding (UNINIT=0, WAIT_ICW2=1, WAIT_ICW3=2, WAIT_ICW4=3, READY=4) and the bit-position constants ICW1_IC4=0, ICW1_SNGL=1, ICW1_MARK=4, OCW_SEL=3.
REQ-029 A sub-module write_commit_detector SHALL contain the capture register and the commit generation; the state machine and decode SHALL live in the top level.

Verification
REQ-030 Reset, then write A0=0 8'h13, then A0=1 8'h20, then A0=1 8'h01 -> ICW1, ICW2 and ICW4 strobes only; initialization_done=1 after the third commit.
REQ-031 Write 8'h11, 8'h08, 8'h04, 8'h01 -> ICW1–ICW4 strobes in order; internal_data_bus=8'h04 during the ICW3 strobe.
REQ-032 In READY, write A0=1 8'hFF, A0=0 8'h20, A0=0 8'h0B -> OCW1, OCW2, OCW3 strobes; A0=0 8'h18 -> sequence_error only.
REQ-033 After reset with ALLOW_OCW_BEFORE_INIT=0, write A0=1 8'hAA -> sequence_error, no strobe, state stays UNINIT.
REQ-034 Drop reset_n in WAIT_ICW3, then release it and write A0=1 8'h04 -> no strobe, sequence_error; state is UNINIT.
REQ-035 Write A0=0 8'h13 in READY -> ICW1 strobe, initialization_done falls to 0, state becomes WAIT_ICW2.

Source files
------------

// File: rtl/command_word_sequencer_pkg.sv
// Shared state encoding, ICW/OCW bit positions and strobe bundle for the
// command word sequencer and its write commit detector.
package command_word_sequencer_pkg;

    typedef enum logic [2:0] {
        UNINIT    = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } seq_state_e;

    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;
    localparam int ICW1_MARK = 4;
    localparam int OCW_SEL   = 3;

    typedef struct packed {
        logic       cs_n;
        logic       we_n;
        logic       addr;
        logic [7:0] data;
    } capture_t;

    localparam capture_t CAPTURE_IDLE = '{cs_n: 1'b1, we_n: 1'b1, addr: 1'b0, data: 8'h00};

    typedef struct packed {
        logic       seq_err;
        logic [3:1] ocw;
        logic [4:1] icw;
    } strobe_t;

    localparam strobe_t STROBE_NONE = '0;

    // Decode of a non-ICW1 write once initialization is complete.
    function automatic strobe_t ocw_decode(input logic address, input logic [7:0] data);
        strobe_t s;
        s = STROBE_NONE;
        if (address) begin
            s.ocw[1] = 1'b1;
        end else begin
            case ({data[ICW1_MARK], data[OCW_SEL]})
                2'b00:   s.ocw[2]  = 1'b1;
                2'b01:   s.ocw[3]  = 1'b1;
                default: s.seq_err = 1'b1;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/command_word_sequencer_write_commit_detector.sv
// Samples the CPU bus every cycle and flags a commit when the sampled write
// strobe rises, using select/address/data from the last low-strobe cycle.
module write_commit_detector
    import command_word_sequencer_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       chip_select_n,
    input  logic       write_enable_n,
    input  logic       address,
    input  logic [7:0] data_bus_in,
    output logic       commit,
    output logic       commit_address,
    output logic [7:0] commit_data
);

    capture_t sample_q, sample_d;
    capture_t last_q, last_d;

    always_comb begin
        sample_d = '{cs_n: chip_select_n, we_n: write_enable_n,
                     addr: address, data: data_bus_in};
        last_d   = sample_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sample_q <= CAPTURE_IDLE;
            last_q   <= CAPTURE_IDLE;
        end else begin
            sample_q <= sample_d;
            last_q   <= last_d;
        end
    end

    // last_q is the final low-strobe sample whenever the strobe has just risen
    assign commit         = sample_q.we_n && !last_q.we_n && !last_q.cs_n;
    assign commit_address = last_q.addr;
    assign commit_data    = last_q.data;

endmodule

// File: rtl/command_word_sequencer.sv
// ICW1-ICW4 initialization sequencer and OCW1-OCW3 decoder driven by
// committed CPU writes; all outputs are registered one-cycle pulses.
module command_word_sequencer
    import command_word_sequencer_pkg::*;
#(
    parameter bit ALLOW_OCW_BEFORE_INIT = 1'b0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       chip_select_n,
    input  logic       write_enable_n,
    input  logic       address,
    input  logic [7:0] data_bus_in,
    output logic [7:0] internal_data_bus,
    output logic       write_initial_command_word_1,
    output logic       write_initial_command_word_2,
    output logic       write_initial_command_word_3,
    output logic       write_initial_command_word_4,
    output logic       write_operation_control_word_1,
    output logic       write_operation_control_word_2,
    output logic       write_operation_control_word_3,
    output logic       initialization_done,
    output logic       sequence_error
);

    logic       commit;
    logic       commit_address;
    logic [7:0] commit_data;

    write_commit_detector u_commit (
        .clock          (clock),
        .reset_n        (reset_n),
        .chip_select_n  (chip_select_n),
        .write_enable_n (write_enable_n),
        .address        (address),
        .data_bus_in    (data_bus_in),
        .commit         (commit),
        .commit_address (commit_address),
        .commit_data    (commit_data)
    );

    seq_state_e state_q, state_d;
    logic       sngl_q, sngl_d;
    logic       ic4_q, ic4_d;
    logic [7:0] data_q, data_d;
    strobe_t    strobe_q, strobe_d;
    logic       icw1_hit;

    always_comb begin
        state_d  = state_q;
        sngl_d   = sngl_q;
        ic4_d    = ic4_q;
        data_d   = data_q;
        strobe_d = STROBE_NONE;
        // In READY, data[4:3]=11 is an illegal OCW rather than a new ICW1.
        icw1_hit = !commit_address && commit_data[ICW1_MARK] &&
                   !(state_q == READY && commit_data[OCW_SEL]);

        if (commit) begin
            data_d = commit_data;
            if (icw1_hit) begin
                strobe_d.icw[1] = 1'b1;
                sngl_d          = commit_data[ICW1_SNGL];
                ic4_d           = commit_data[ICW1_IC4];
                state_d         = WAIT_ICW2;
            end else begin
                case (state_q)
                    WAIT_ICW2: begin
                        if (commit_address) begin
                            strobe_d.icw[2] = 1'b1;
                            if (!sngl_q)    state_d = WAIT_ICW3;
                            else if (ic4_q) state_d = WAIT_ICW4;
                            else            state_d = READY;
                        end else begin
                            strobe_d.seq_err = 1'b1;
                        end
                    end
                    WAIT_ICW3: begin
                        if (commit_address) begin
                            strobe_d.icw[3] = 1'b1;
                            state_d         = ic4_q ? WAIT_ICW4 : READY;
                        end else begin
                            strobe_d.seq_err = 1'b1;
                        end
                    end
                    WAIT_ICW4: begin
                        if (commit_address) begin
                            strobe_d.icw[4] = 1'b1;
                            state_d         = READY;
                        end else begin
                            strobe_d.seq_err = 1'b1;
                        end
                    end
                    READY: begin
                        strobe_d = ocw_decode(commit_address, commit_data);
                    end
                    UNINIT: begin
                        if (ALLOW_OCW_BEFORE_INIT) strobe_d = ocw_decode(commit_address, commit_data);
                        else                       strobe_d.seq_err = 1'b1;
                    end
                    default: begin
                        strobe_d.seq_err = 1'b1;
                        state_d          = UNINIT;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= UNINIT;
            sngl_q   <= 1'b0;
            ic4_q    <= 1'b0;
            data_q   <= 8'h00;
            strobe_q <= STROBE_NONE;
        end else begin
            state_q  <= state_d;
            sngl_q   <= sngl_d;
            ic4_q    <= ic4_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
        end
    end

    assign internal_data_bus              = data_q;
    assign write_initial_command_word_1   = strobe_q.icw[1];
    assign write_initial_command_word_2   = strobe_q.icw[2];
    assign write_initial_command_word_3   = strobe_q.icw[3];
    assign write_initial_command_word_4   = strobe_q.icw[4];
    assign write_operation_control_word_1 = strobe_q.ocw[1];
    assign write_operation_control_word_2 = strobe_q.ocw[2];
    assign write_operation_control_word_3 = strobe_q.ocw[3];
    assign sequence_error                 = strobe_q.seq_err;
    assign initialization_done            = (state_q == READY);

endmodule

// File: tb/tb_command_word_sequencer.sv
// Bench for command_word_sequencer: one instance with OCW-before-init blocked,
// one with it allowed, both checked against a pending-ICW reference model.
module tb_command_word_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       chip_select_n = 1'b1;
    logic       write_enable_n = 1'b1;
    logic       address = 1'b0;
    logic [7:0] data_bus_in = 8'h00;

    logic [7:0] idb0, idb1;
    logic i1_0, i2_0, i3_0, i4_0, o1_0, o2_0, o3_0, dn_0, er_0;
    logic i1_1, i2_1, i3_1, i4_1, o1_1, o2_1, o3_1, dn_1, er_1;

    always #5 clock = ~clock;

    command_word_sequencer #(.ALLOW_OCW_BEFORE_INIT(1'b0)) dut0 (
        .clock(clock), .reset_n(reset_n), .chip_select_n(chip_select_n),
        .write_enable_n(write_enable_n), .address(address), .data_bus_in(data_bus_in),
        .internal_data_bus(idb0),
        .write_initial_command_word_1(i1_0), .write_initial_command_word_2(i2_0),
        .write_initial_command_word_3(i3_0), .write_initial_command_word_4(i4_0),
        .write_operation_control_word_1(o1_0), .write_operation_control_word_2(o2_0),
        .write_operation_control_word_3(o3_0),
        .initialization_done(dn_0), .sequence_error(er_0)
    );

    command_word_sequencer #(.ALLOW_OCW_BEFORE_INIT(1'b1)) dut1 (
        .clock(clock), .reset_n(reset_n), .chip_select_n(chip_select_n),
        .write_enable_n(write_enable_n), .address(address), .data_bus_in(data_bus_in),
        .internal_data_bus(idb1),
        .write_initial_command_word_1(i1_1), .write_initial_command_word_2(i2_1),
        .write_initial_command_word_3(i3_1), .write_initial_command_word_4(i4_1),
        .write_operation_control_word_1(o1_1), .write_operation_control_word_2(o2_1),
        .write_operation_control_word_3(o3_1),
        .initialization_done(dn_1), .sequence_error(er_1)
    );

    // Strobe vector: {err, ocw3, ocw2, ocw1, icw4, icw3, icw2, icw1}
    localparam logic [7:0] S_I1 = 8'h01, S_I2 = 8'h02, S_I3 = 8'h04, S_I4 = 8'h08;
    localparam logic [7:0] S_O1 = 8'h10, S_O2 = 8'h20, S_O3 = 8'h40, S_ER = 8'h80;

    int checks = 0;
    int errors = 0;

    function automatic logic [7:0] strb0();
        return {er_0, o3_0, o2_0, o1_0, i4_0, i3_0, i2_0, i1_0};
    endfunction
    function automatic logic [7:0] strb1();
        return {er_1, o3_1, o2_1, o1_1, i4_1, i3_1, i2_1, i1_1};
    endfunction

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Reference model: the set of ICWs still owed after the last ICW1, and
    // whether a full initialization has completed since then.
    logic [4:2] need [2];
    bit         inited [2];
    logic [7:0] exp_data;

    function automatic void mdl_reset();
        for (int m = 0; m < 2; m++) begin
            need[m]   = 3'b000;
            inited[m] = 1'b0;
        end
        exp_data = 8'h00;
    endfunction

    function automatic logic [7:0] mdl(input int m, input bit a, input logic [7:0] d);
        int k;
        if (!a && d[4] && !(inited[m] && d[3])) begin
            need[m]   = {d[0], ~d[1], 1'b1};
            inited[m] = 1'b0;
            return S_I1;
        end
        if (need[m] != 3'b000) begin
            if (!a) return S_ER;
            k = 0;
            for (int j = 4; j >= 2; j--) if (need[m][j]) k = j;
            need[m][k] = 1'b0;
            if (need[m] == 3'b000) inited[m] = 1'b1;
            return 8'(1 << (k - 1));
        end
        if (!(inited[m] || m == 1)) return S_ER;
        if (a) return S_O1;
        if (d[4]) return S_ER;
        return d[3] ? S_O3 : S_O2;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0; chip_select_n = 1'b1; write_enable_n = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("rst_strobe0", strb0(), 8'h00);
        chk("rst_strobe1", strb1(), 8'h00);
        chk("rst_data0", idb0, 8'h00);
        chk("rst_data1", idb1, 8'h00);
        chk("rst_done0", 8'(dn_0), 8'h00);
        chk("rst_done1", 8'(dn_1), 8'h00);
        @(negedge clock);
        reset_n = 1'b1;
        mdl_reset();
    endtask

    // One write with a 1- or 2-cycle low strobe; cs_l/d are the last-low values.
    task automatic do_write(input bit a, input logic [7:0] d, input int nlow,
                            input bit cs_e, input logic [7:0] d_e, input bit cs_l,
                            output logic [7:0] g0, output bit dn0);
        logic [7:0] e0, e1;
        if (nlow == 2) begin
            @(negedge clock);
            chip_select_n = cs_e; write_enable_n = 1'b0; address = a; data_bus_in = d_e;
        end
        @(negedge clock);
        chip_select_n = cs_l; write_enable_n = 1'b0; address = a; data_bus_in = d;
        @(negedge clock);
        write_enable_n = 1'b1;
        chip_select_n  = 1'($urandom_range(0, 1));
        address        = 1'($urandom_range(0, 1));
        data_bus_in    = 8'($urandom);
        e0 = 8'h00;
        e1 = 8'h00;
        if (!cs_l) begin
            e0 = mdl(0, a, d);
            e1 = mdl(1, a, d);
            exp_data = d;
        end
        @(posedge clock);
        @(posedge clock); #1;
        g0  = strb0();
        dn0 = dn_0;
        chk("strobe0", g0, e0);
        chk("strobe1", strb1(), e1);
        chk("data0", idb0, exp_data);
        chk("data1", idb1, exp_data);
        chk("done0", 8'(dn_0), 8'(inited[0]));
        chk("done1", 8'(dn_1), 8'(inited[1]));
        @(posedge clock); #1;
        chk("pulse_end0", strb0(), 8'h00);
        chk("pulse_end1", strb1(), 8'h00);
    endtask

    typedef struct {
        bit         rst;
        bit         a;
        logic [7:0] d;
        logic [7:0] exp_s;
        bit         exp_done;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rst, input bit a, input logic [7:0] d,
                       input logic [7:0] s, input bit dn);
        vec_t v;
        v.rst = rst; v.a = a; v.d = d; v.exp_s = s; v.exp_done = dn;
        tbl.push_back(v);
    endtask

    initial begin
        logic [7:0] g0;
        bit         dn0;
        bit         a;
        logic [7:0] d;

        mdl_reset();
        // Expected values for the ALLOW_OCW_BEFORE_INIT=0 instance.
        add(1, 1, 8'hAA, S_ER, 0);  // OCW before init is rejected
        add(0, 0, 8'h13, S_I1, 0);  // single, IC4
        add(0, 1, 8'h20, S_I2, 0);
        add(0, 1, 8'h01, S_I4, 1);
        add(0, 1, 8'hFF, S_O1, 1);
        add(0, 0, 8'h20, S_O2, 1);
        add(0, 0, 8'h0B, S_O3, 1);
        add(0, 0, 8'h18, S_ER, 1);  // data[4:3]=11 in READY
        add(0, 0, 8'h13, S_I1, 0);  // re-init from READY
        add(0, 0, 8'h05, S_ER, 0);  // A0=0 non-ICW1 while waiting
        add(0, 1, 8'h20, S_I2, 0);
        add(0, 1, 8'h01, S_I4, 1);
        add(0, 0, 8'h11, S_I1, 0);  // cascade, IC4
        add(0, 1, 8'h08, S_I2, 0);
        add(0, 1, 8'h04, S_I3, 0);
        add(0, 1, 8'h01, S_I4, 1);
        add(0, 0, 8'h12, S_I1, 0);  // single, no IC4: READY straight after ICW2
        add(0, 1, 8'h00, S_I2, 1);
        add(0, 0, 8'h10, S_I1, 0);  // cascade, no IC4
        add(0, 1, 8'h00, S_I2, 0);  // now waiting for ICW3
        add(1, 1, 8'h04, S_ER, 0);  // reset mid-sequence drops back to UNINIT

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            do_write(tbl[i].a, tbl[i].d, 1, 1'b1, 8'h00, 1'b0, g0, dn0);
            chk("tbl_strobe", g0, tbl[i].exp_s);
            chk("tbl_done", 8'(dn0), 8'(tbl[i].exp_done));
        end

        // Get to READY, then exercise chip-select corner cases.
        do_write(0, 8'h12, 1, 1'b1, 8'h00, 1'b0, g0, dn0);
        do_write(1, 8'h00, 1, 1'b1, 8'h00, 1'b0, g0, dn0);
        do_write(1, 8'h77, 1, 1'b1, 8'h00, 1'b1, g0, dn0);  // deselected: ignored
        chk("cs_high_ignored", g0, 8'h00);
        do_write(1, 8'h66, 2, 1'b0, 8'h55, 1'b1, g0, dn0);  // cs drops away before rise
        chk("cs_late_high", g0, 8'h00);
        do_write(1, 8'hC3, 2, 1'b1, 8'h3C, 1'b0, g0, dn0);  // cs arrives in last-low cycle
        chk("cs_late_low", g0, S_O1);

        // Reset landing on the strobe rise must swallow the pending commit.
        @(negedge clock);
        chip_select_n = 1'b0; write_enable_n = 1'b0; address = 1'b1; data_bus_in = 8'h55;
        @(negedge clock);
        chip_select_n = 1'b1; write_enable_n = 1'b1; reset_n = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        reset_n = 1'b1;
        mdl_reset();
        for (int c = 0; c < 2; c++) begin
            @(posedge clock); #1;
            chk("pending_sup0", strb0(), 8'h00);
            chk("pending_sup1", strb1(), 8'h00);
        end
        chk("pending_data0", idb0, 8'h00);

        // Randomized traffic against the model.
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 29) == 0) do_reset();
            a = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            if (!a && $urandom_range(0, 2) == 0) d[4] = 1'b0;
            do_write(a, d, $urandom_range(1, 2), 1'($urandom_range(0, 1)), 8'($urandom),
                     ($urandom_range(0, 9) == 0), g0, dn0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
